// File: rtl/vga_timing_param.sv
// vga_timing_param
//   Parametrised VGA timing generator sitting between a framebuffer RAM and
//   the VGA pins. The fetch address is produced from the raw counters; all
//   pin outputs are delayed to match the RAM read latency so that each pixel
//   leaves the pins together with its own sync/blank state.
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   enable       run timing; low holds counters at 0 and blanks the pins
//   mode_565     pixel format: 1 = RGB565, 0 = RGB332 in data[7:0]
//   scale_2x     show each framebuffer pixel as a 2x2 block
//   data         pixel data returned by the framebuffer
//   address      {fy[9:0], fx[9:0]} fetch address (0 outside visible area)
//   fetch_valid  address is inside the visible area
//   h_sync       horizontal sync, active level H_SYNC_POL
//   v_sync       vertical sync, active level V_SYNC_POL
//   video_enable pins carry a visible pixel
//   red/green/blue  colour pins
//   frame_start  one-cycle pulse with the first visible pixel of a frame
module vga_timing_param #(
   parameter int   H_VISIBLE     = 640,
   parameter int   H_FRONT       = 16,
   parameter int   H_SYNC        = 96,
   parameter int   H_BACK        = 48,
   parameter int   V_VISIBLE     = 480,
   parameter int   V_FRONT       = 10,
   parameter int   V_SYNC        = 2,
   parameter int   V_BACK        = 33,
   parameter logic H_SYNC_POL    = 1'b0,
   parameter logic V_SYNC_POL    = 1'b0,
   parameter int   FETCH_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        mode_565,
   input  logic        scale_2x,
   input  logic [15:0] data,
   output logic [19:0] address,
   output logic        fetch_valid,
   output logic        h_sync,
   output logic        v_sync,
   output logic        video_enable,
   output logic [4:0]  red,
   output logic [5:0]  green,
   output logic [4:0]  blue,
   output logic        frame_start
);

   localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
   localparam logic [10:0] H_SBEG = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] H_SEND = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] H_LAST = 11'(HT - 1);
   localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
   localparam logic [10:0] V_SBEG = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] V_SEND = 11'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [10:0] V_LAST = 11'(VT - 1);

   if (H_VISIBLE < 1 || H_VISIBLE > 1024 || V_VISIBLE < 1 || V_VISIBLE > 1024 ||
       H_FRONT < 0 || H_BACK < 0 || V_FRONT < 0 || V_BACK < 0 ||
       H_SYNC < 1 || V_SYNC < 1 || HT > 2048 || VT > 2048 ||
       FETCH_LATENCY < 0 || FETCH_LATENCY > 4) begin : g_bad_params
      $error("vga_timing_param: illegal timing parameters");
   end

   // Per-pixel control that travels alongside the RAM read.
   typedef struct packed {
      logic vis;
      logic hs;
      logic vs;
      logic first;
      logic m565;
   } stage_t;

   logic [10:0] hc_q, hc_d, vc_q, vc_d;
   logic        run_q, run_d;
   logic        mode_q, mode_d, scale_q, scale_d;
   stage_t      st0, st_dly;

   logic        hs_q, hs_d, vs_q, vs_d, ve_q, ve_d, fs_q, fs_d;
   logic [15:0] rgb_q, rgb_d;

   // run_q is enable seen one edge late: the first running cycle after a
   // rising enable (or reset release) is always (0,0), and stage 0 is idle
   // while in reset, so fetch_valid is 0 there.
   always_comb begin
      run_d   = enable;
      hc_d    = hc_q;
      vc_d    = vc_q;
      mode_d  = mode_q;
      scale_d = scale_q;
      if (!(enable && run_q)) begin
         hc_d = '0;
         vc_d = '0;
      end else if (hc_q == H_LAST) begin
         hc_d = '0;
         vc_d = (vc_q == V_LAST) ? 11'd0 : vc_q + 11'd1;
      end else begin
         hc_d = hc_q + 11'd1;
      end
      // Format/scale only change on the frame boundary.
      if (run_q && hc_q == H_LAST && vc_q == V_LAST) begin
         mode_d  = mode_565;
         scale_d = scale_2x;
      end
   end

   always_comb begin
      st0.vis   = run_q && (hc_q < H_VIS) && (vc_q < V_VIS);
      st0.hs    = run_q && (hc_q >= H_SBEG) && (hc_q < H_SEND);
      st0.vs    = run_q && (vc_q >= V_SBEG) && (vc_q < V_SEND);
      st0.first = run_q && (hc_q == 11'd0) && (vc_q == 11'd0);
      st0.m565  = mode_q;
   end

   always_comb begin
      address = '0;
      if (st0.vis)
         address = scale_q ? {vc_q[10:1], hc_q[10:1]} : {vc_q[9:0], hc_q[9:0]};
   end
   assign fetch_valid = st0.vis;

   // Delay line matching the RAM read latency.
   if (FETCH_LATENCY == 0) begin : g_nopipe
      assign st_dly = st0;
   end else begin : g_pipe
      stage_t [FETCH_LATENCY-1:0] pipe_q, pipe_d;
      always_comb begin
         pipe_d    = pipe_q;
         pipe_d[0] = st0;
         for (int i = 1; i < FETCH_LATENCY; i++)
            pipe_d[i] = pipe_q[i-1];
      end
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) pipe_q <= '0;
         else        pipe_q <= pipe_d;
      end
      assign st_dly = pipe_q[FETCH_LATENCY-1];
   end

   always_comb begin
      rgb_d = '0;
      if (st_dly.vis)
         rgb_d = st_dly.m565 ? data
                             : {data[7:5], data[7:6], data[4:2], data[4:2],
                                data[1:0], data[1:0], data[1]};
      hs_d = st_dly.hs ? H_SYNC_POL : ~H_SYNC_POL;
      vs_d = st_dly.vs ? V_SYNC_POL : ~V_SYNC_POL;
      ve_d = st_dly.vis;
      fs_d = st_dly.first;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hc_q    <= '0;
         vc_q    <= '0;
         run_q   <= 1'b0;
         mode_q  <= 1'b0;
         scale_q <= 1'b0;
         hs_q    <= ~H_SYNC_POL;
         vs_q    <= ~V_SYNC_POL;
         ve_q    <= 1'b0;
         fs_q    <= 1'b0;
         rgb_q   <= '0;
      end else begin
         hc_q    <= hc_d;
         vc_q    <= vc_d;
         run_q   <= run_d;
         mode_q  <= mode_d;
         scale_q <= scale_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         ve_q    <= ve_d;
         fs_q    <= fs_d;
         rgb_q   <= rgb_d;
      end
   end

   assign h_sync       = hs_q;
   assign v_sync       = vs_q;
   assign video_enable = ve_q;
   assign frame_start  = fs_q;
   assign red          = rgb_q[15:11];
   assign green        = rgb_q[10:5];
   assign blue         = rgb_q[4:0];

endmodule
